// File: rtl/pwm_breath_seq.sv
// pwm_breath_seq
// Sequencer for one or more pwm_ctr instances. It owns the shared period
// counter, the per-period duty (percent) and the rate word. The period length
// is CLK_HZ/rate, found with an iterative restoring divider. The duty ramps
// up, holds, ramps down and holds again, giving an LED "breathing" pattern.
// Duty, phase and rate only change on period boundaries, so a period in
// flight is never cut short or reshaped.
//
// Ports:
//   clk, rst_n        clock; asynchronous active-low reset
//   en                run request (level)
//   rate_in           requested PWM frequency in Hz (0 acts as 1)
//   step              duty change per update, percent
//   periods_per_step  periods between duty updates (0 acts as 1)
//   hold_periods      periods held at each end of the ramp (0 = no hold)
//   cnt               shared period counter
//   duty              current duty, percent
//   rate              rate the current period length was computed for
//   period_top        last cnt value of a period (CLK_HZ/rate - 1)
//   period_start      high on the cycles where cnt==0 while running
//   busy              high while the divider runs
//   phase             0=UP, 1=HOLD_HI, 2=DOWN, 3=HOLD_LO
module pwm_breath_seq #(
  parameter int unsigned CLK_HZ   = 27_000_000,
  parameter int unsigned DUTY_MAX = 100,
  parameter int unsigned DUTY_MIN = 0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        en,
  input  logic [31:0] rate_in,
  input  logic [7:0]  step,
  input  logic [15:0] periods_per_step,
  input  logic [15:0] hold_periods,
  output logic [31:0] cnt,
  output logic [31:0] duty,
  output logic [31:0] rate,
  output logic [31:0] period_top,
  output logic        period_start,
  output logic        busy,
  output logic [1:0]  phase
);

  localparam logic [31:0] DIVIDEND = 32'(CLK_HZ);
  localparam logic [31:0] D_MAX    = 32'(DUTY_MAX);
  localparam logic [31:0] D_MIN    = 32'(DUTY_MIN);

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_RUN} state_t;
  typedef enum logic [1:0] {PH_UP = 2'd0, PH_HOLD_HI = 2'd1,
                            PH_DOWN = 2'd2, PH_HOLD_LO = 2'd3} phase_t;

  state_t      state_q, state_d;
  phase_t      phase_q, phase_d, phase_seq;
  logic [31:0] cnt_q, cnt_d;
  logic [31:0] duty_q, duty_d, duty_seq;
  logic [31:0] rate_q, rate_d;
  logic [31:0] period_top_q, period_top_d;
  logic        period_start_q, period_start_d;
  logic [31:0] pc_q, pc_d, pc_seq;
  logic [31:0] rate_l_q, rate_l_d;
  logic [31:0] rem_q, rem_d;
  logic [31:0] quo_q, quo_d;
  logic [4:0]  div_bit_q, div_bit_d;

  logic [31:0] rate_in_eff, pps_eff, hold_eff, pc_inc;
  logic        boundary;
  logic [4:0]  div_idx;
  logic [32:0] rem_shift;
  logic        q_bit;
  logic [31:0] rem_next, quo_next;
  logic [32:0] sum_up, floor_dn;

  assign rate_in_eff = (rate_in == 32'd0) ? 32'd1 : rate_in;
  assign pps_eff     = (periods_per_step == 16'd0) ? 32'd1 : {16'd0, periods_per_step};
  assign hold_eff    = {16'd0, hold_periods};
  assign pc_inc      = pc_q + 32'd1;
  assign boundary    = (cnt_q == period_top_q);

  // One restoring-divider step: the working remainder is 33 bits wide
  // (stored remainder shifted left plus the next dividend bit, MSB first).
  // After subtraction the remainder is below the divisor, so 32 stored bits
  // are enough.
  always_comb begin
    div_idx   = 5'd31 - div_bit_q;
    rem_shift = {rem_q, DIVIDEND[div_idx]};
    q_bit     = (rem_shift >= {1'b0, rate_l_q});
    rem_next  = q_bit ? (rem_shift[31:0] - rate_l_q) : rem_shift[31:0];
    quo_next  = quo_q;
    quo_next[div_idx] = q_bit;
  end

  // Breathing sequencer: what duty/phase/pc become if the current edge is a
  // period boundary. pc counts periods towards a duty step while ramping and
  // counts held periods while holding.
  always_comb begin
    duty_seq  = duty_q;
    phase_seq = phase_q;
    pc_seq    = pc_q;
    sum_up    = {1'b0, duty_q} + {25'd0, step};
    floor_dn  = {1'b0, D_MIN} + {25'd0, step};
    case (phase_q)
      PH_UP: begin
        if (pc_inc >= pps_eff) begin
          pc_seq   = 32'd0;
          duty_seq = (sum_up >= {1'b0, D_MAX}) ? D_MAX : sum_up[31:0];
          if (duty_seq == D_MAX) begin
            phase_seq = (hold_periods == 16'd0) ? PH_DOWN : PH_HOLD_HI;
          end
        end else begin
          pc_seq = pc_inc;
        end
      end
      PH_HOLD_HI: begin
        if (pc_inc >= hold_eff) begin
          pc_seq    = 32'd0;
          phase_seq = PH_DOWN;
        end else begin
          pc_seq = pc_inc;
        end
      end
      PH_DOWN: begin
        if (pc_inc >= pps_eff) begin
          pc_seq   = 32'd0;
          duty_seq = ({1'b0, duty_q} <= floor_dn) ? D_MIN : (duty_q - {24'd0, step});
          if (duty_seq == D_MIN) begin
            phase_seq = (hold_periods == 16'd0) ? PH_UP : PH_HOLD_LO;
          end
        end else begin
          pc_seq = pc_inc;
        end
      end
      PH_HOLD_LO: begin
        if (pc_inc >= hold_eff) begin
          pc_seq    = 32'd0;
          phase_seq = PH_UP;
        end else begin
          pc_seq = pc_inc;
        end
      end
      default: ;
    endcase
  end

  // Main control: IDLE waits for en, CALC runs the 32 divider steps, RUN
  // counts periods. Leaving RUN (stop or rate change) only happens on a
  // boundary so the last period always completes.
  always_comb begin
    state_d      = state_q;
    phase_d      = phase_q;
    cnt_d        = cnt_q;
    duty_d       = duty_q;
    rate_d       = rate_q;
    period_top_d = period_top_q;
    pc_d         = pc_q;
    rate_l_d     = rate_l_q;
    rem_d        = rem_q;
    quo_d        = quo_q;
    div_bit_d    = div_bit_q;
    case (state_q)
      S_IDLE: begin
        cnt_d   = 32'd0;
        duty_d  = D_MIN;
        phase_d = PH_UP;
        pc_d    = 32'd0;
        if (en) begin
          rate_l_d  = rate_in_eff;
          rem_d     = 32'd0;
          quo_d     = 32'd0;
          div_bit_d = 5'd0;
          state_d   = S_CALC;
        end
      end
      S_CALC: begin
        cnt_d = 32'd0;
        if (!en) begin
          state_d = S_IDLE;
          duty_d  = D_MIN;
          phase_d = PH_UP;
          pc_d    = 32'd0;
        end else begin
          rem_d     = rem_next;
          quo_d     = quo_next;
          div_bit_d = div_bit_q + 5'd1;
          if (div_bit_q == 5'd31) begin
            // A zero quotient (rate above CLK_HZ) pins the period to one cycle.
            period_top_d = (quo_next == 32'd0) ? 32'd0 : (quo_next - 32'd1);
            rate_d       = rate_l_q;
            state_d      = S_RUN;
          end
        end
      end
      S_RUN: begin
        if (boundary) begin
          cnt_d = 32'd0;
          if (!en) begin
            state_d = S_IDLE;
            duty_d  = D_MIN;
            phase_d = PH_UP;
            pc_d    = 32'd0;
          end else begin
            duty_d  = duty_seq;
            phase_d = phase_seq;
            pc_d    = pc_seq;
            if (rate_in_eff != rate_q) begin
              rate_l_d  = rate_in_eff;
              rem_d     = 32'd0;
              quo_d     = 32'd0;
              div_bit_d = 5'd0;
              state_d   = S_CALC;
            end
          end
        end else begin
          cnt_d = cnt_q + 32'd1;
        end
      end
      default: state_d = S_IDLE;
    endcase
    period_start_d = (state_d == S_RUN) && (cnt_d == 32'd0);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= S_IDLE;
      phase_q        <= PH_UP;
      cnt_q          <= 32'd0;
      duty_q         <= D_MIN;
      rate_q         <= 32'd0;
      period_top_q   <= 32'd0;
      period_start_q <= 1'b0;
      pc_q           <= 32'd0;
      rate_l_q       <= 32'd0;
      rem_q          <= 32'd0;
      quo_q          <= 32'd0;
      div_bit_q      <= 5'd0;
    end else begin
      state_q        <= state_d;
      phase_q        <= phase_d;
      cnt_q          <= cnt_d;
      duty_q         <= duty_d;
      rate_q         <= rate_d;
      period_top_q   <= period_top_d;
      period_start_q <= period_start_d;
      pc_q           <= pc_d;
      rate_l_q       <= rate_l_d;
      rem_q          <= rem_d;
      quo_q          <= quo_d;
      div_bit_q      <= div_bit_d;
    end
  end

  assign cnt          = cnt_q;
  assign duty         = duty_q;
  assign rate         = rate_q;
  assign period_top   = period_top_q;
  assign period_start = period_start_q;
  assign busy         = (state_q == S_CALC);
  assign phase        = phase_q;

endmodule

// File: tb/tb_pwm_breath_seq.sv
// tb_pwm_breath_seq
// Self-checking bench for pwm_breath_seq. Expected period lengths come from
// plain division of the clock rate; expected duty/phase per period come from
// a schedule built segment by segment (climb, hold, fall, hold).
module tb_pwm_breath_seq;

  localparam int unsigned CLK_HZ = 27_000_000;
  localparam int unsigned DMAX   = 100;
  localparam int unsigned DMIN   = 0;

  logic        clk;
  logic        rst_n;
  logic        en;
  logic [31:0] rate_in;
  logic [7:0]  step;
  logic [15:0] periods_per_step;
  logic [15:0] hold_periods;
  logic [31:0] cnt;
  logic [31:0] duty;
  logic [31:0] rate;
  logic [31:0] period_top;
  logic        period_start;
  logic        busy;
  logic [1:0]  phase;

  int unsigned tests_run;
  int unsigned tests_failed;

  int unsigned sched_duty[$];
  logic [1:0]  sched_phase[$];

  pwm_breath_seq #(.CLK_HZ(CLK_HZ), .DUTY_MAX(DMAX), .DUTY_MIN(DMIN)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .rate_in(rate_in), .step(step),
    .periods_per_step(periods_per_step), .hold_periods(hold_periods),
    .cnt(cnt), .duty(duty), .rate(rate), .period_top(period_top),
    .period_start(period_start), .busy(busy), .phase(phase)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected last cnt value of a period for a requested rate.
  function automatic logic [31:0] calc_top(input logic [31:0] r);
    logic [31:0] rr;
    logic [31:0] q;
    rr = (r == 32'd0) ? 32'd1 : r;
    q  = CLK_HZ / rr;
    return (q == 32'd0) ? 32'd0 : q - 32'd1;
  endfunction

  // Per-period (duty, phase) list starting at the first period after CALC.
  task automatic build_schedule(input int unsigned n, input int unsigned st,
                                input int unsigned pp, input int unsigned hd);
    int unsigned d;
    int unsigned ppe;
    sched_duty.delete();
    sched_phase.delete();
    ppe = (pp == 0) ? 1 : pp;
    d   = DMIN;
    while (sched_duty.size() < int'(n)) begin
      if (st == 0) begin
        sched_duty.push_back(d);
        sched_phase.push_back(2'd0);
      end else begin
        while (d < DMAX) begin
          for (int i = 0; i < int'(ppe); i++) begin
            sched_duty.push_back(d); sched_phase.push_back(2'd0);
          end
          d = (d + st >= DMAX) ? DMAX : d + st;
        end
        for (int i = 0; i < int'(hd); i++) begin
          sched_duty.push_back(DMAX); sched_phase.push_back(2'd1);
        end
        while (d > DMIN) begin
          for (int i = 0; i < int'(ppe); i++) begin
            sched_duty.push_back(d); sched_phase.push_back(2'd2);
          end
          d = (d <= DMIN + st) ? DMIN : d - st;
        end
        for (int i = 0; i < int'(hd); i++) begin
          sched_duty.push_back(DMIN); sched_phase.push_back(2'd3);
        end
      end
    end
  endtask

  task automatic do_reset;
    rst_n = 1'b0;
    en = 1'b0;
    rate_in = 32'd0;
    step = 8'd0;
    periods_per_step = 16'd0;
    hold_periods = 16'd0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  // Follows n periods from the first period_start, checking period length,
  // the wrap value and the duty/phase of every period against the schedule.
  task automatic run_schedule(input int n, input logic [31:0] exp_top, input string tag);
    int unsigned el;
    logic [31:0] last_cnt;
    el = 0;
    while (period_start !== 1'b1 && el < 100) begin
      @(negedge clk);
      el++;
    end
    tests_run++;
    if (period_start !== 1'b1) begin
      tests_failed++;
      $display("[TB] FAIL %s first_start: got none expected within 100 cycles", tag);
      return;
    end
    for (int k = 0; k < n; k++) begin
      if (k > 0) begin
        el = 0;
        do begin
          last_cnt = cnt;
          @(negedge clk);
          el++;
        end while (period_start !== 1'b1 && el < exp_top + 10);
        tests_run++;
        if (el != exp_top + 1) begin
          tests_failed++;
          $display("[TB] FAIL %s period_len[%0d]: got %0d expected %0d", tag, k, el, exp_top + 1);
        end
        tests_run++;
        if (last_cnt !== exp_top) begin
          tests_failed++;
          $display("[TB] FAIL %s wrap_cnt[%0d]: got %0d expected %0d", tag, k, last_cnt, exp_top);
        end
      end
      tests_run++;
      if (duty !== sched_duty[k]) begin
        tests_failed++;
        $display("[TB] FAIL %s duty[%0d]: got %0d expected %0d", tag, k, duty, sched_duty[k]);
      end
      tests_run++;
      if (phase !== sched_phase[k]) begin
        tests_failed++;
        $display("[TB] FAIL %s phase[%0d]: got %0d expected %0d", tag, k, phase, sched_phase[k]);
      end
    end
  endtask

  task automatic test_reset;
    do_reset();
    tests_run += 7;
    if (cnt !== 32'd0) begin tests_failed++; $display("[TB] FAIL reset_cnt: got %0d expected 0", cnt); end
    if (duty !== DMIN) begin tests_failed++; $display("[TB] FAIL reset_duty: got %0d expected %0d", duty, DMIN); end
    if (rate !== 32'd0) begin tests_failed++; $display("[TB] FAIL reset_rate: got %0d expected 0", rate); end
    if (period_top !== 32'd0) begin tests_failed++; $display("[TB] FAIL reset_top: got %0d expected 0", period_top); end
    if (period_start !== 1'b0) begin tests_failed++; $display("[TB] FAIL reset_start: got %0b expected 0", period_start); end
    if (busy !== 1'b0) begin tests_failed++; $display("[TB] FAIL reset_busy: got %0b expected 0", busy); end
    if (phase !== 2'd0) begin tests_failed++; $display("[TB] FAIL reset_phase: got %0d expected 0", phase); end
  endtask

  task automatic test_latency_and_rate_change;
    int unsigned n_busy, first_ps, cnt_bad, el;
    logic [31:0] last_cnt;
    do_reset();
    step = 8'd10; periods_per_step = 16'd2; hold_periods = 16'd0;
    rate_in = 32'd1000; en = 1'b1;
    n_busy = 0; first_ps = 0; cnt_bad = 0;
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      if (busy === 1'b1) begin
        n_busy++;
        if (cnt !== 32'd0) cnt_bad++;
      end
      if (period_start === 1'b1 && first_ps == 0) first_ps = i;
    end
    tests_run += 7;
    if (n_busy != 32) begin tests_failed++; $display("[TB] FAIL calc_busy_cycles: got %0d expected 32", n_busy); end
    if (first_ps != 33) begin tests_failed++; $display("[TB] FAIL first_start_latency: got %0d expected 33", first_ps); end
    if (cnt_bad != 0) begin tests_failed++; $display("[TB] FAIL calc_cnt_nonzero: got %0d expected 0", cnt_bad); end
    if (period_top !== calc_top(32'd1000)) begin tests_failed++; $display("[TB] FAIL top_1000: got %0d expected %0d", period_top, calc_top(32'd1000)); end
    if (rate !== 32'd1000) begin tests_failed++; $display("[TB] FAIL rate_1000: got %0d expected 1000", rate); end
    if (duty !== 32'd0) begin tests_failed++; $display("[TB] FAIL duty_first: got %0d expected 0", duty); end
    if (phase !== 2'd0) begin tests_failed++; $display("[TB] FAIL phase_first: got %0d expected 0", phase); end

    el = 0;
    while (cnt !== 32'd5000 && el < 30000) begin @(negedge clk); el++; end
    tests_run++;
    if (cnt !== 32'd5000) begin tests_failed++; $display("[TB] FAIL reach_cnt_5000: got %0d expected 5000", cnt); end
    rate_in = 32'd2000;
    el = 0; last_cnt = cnt;
    while (busy !== 1'b1 && el < 30000) begin last_cnt = cnt; @(negedge clk); el++; end
    tests_run += 2;
    if (el != 22000) begin tests_failed++; $display("[TB] FAIL rate_change_delay: got %0d expected 22000", el); end
    if (last_cnt !== 32'd26999) begin tests_failed++; $display("[TB] FAIL wrap_26999: got %0d expected 26999", last_cnt); end
    n_busy = 0; cnt_bad = 0;
    while (busy === 1'b1 && n_busy < 100) begin
      n_busy++;
      if (cnt !== 32'd0) cnt_bad++;
      @(negedge clk);
    end
    tests_run += 7;
    if (n_busy != 32) begin tests_failed++; $display("[TB] FAIL recalc_busy_cycles: got %0d expected 32", n_busy); end
    if (cnt_bad != 0) begin tests_failed++; $display("[TB] FAIL recalc_cnt_nonzero: got %0d expected 0", cnt_bad); end
    if (period_start !== 1'b1) begin tests_failed++; $display("[TB] FAIL recalc_start: got %0b expected 1", period_start); end
    if (period_top !== calc_top(32'd2000)) begin tests_failed++; $display("[TB] FAIL top_2000: got %0d expected %0d", period_top, calc_top(32'd2000)); end
    if (rate !== 32'd2000) begin tests_failed++; $display("[TB] FAIL rate_2000: got %0d expected 2000", rate); end
    if (duty !== 32'd0) begin tests_failed++; $display("[TB] FAIL duty_kept: got %0d expected 0", duty); end
    if (phase !== 2'd0) begin tests_failed++; $display("[TB] FAIL phase_kept: got %0d expected 0", phase); end
    // pc reached 1 at the boundary before CALC, so the next boundary steps.
    el = 0;
    do begin @(negedge clk); el++; end while (period_start !== 1'b1 && el < 20000);
    tests_run += 2;
    if (el != 13500) begin tests_failed++; $display("[TB] FAIL period_2000: got %0d expected 13500", el); end
    if (duty !== 32'd10) begin tests_failed++; $display("[TB] FAIL duty_after_recalc: got %0d expected 10", duty); end
  endtask

  task automatic test_divider;
    logic [31:0] r, r_norm;
    int unsigned el, bad;
    for (int i = 0; i < 7; i++) begin
      case (i)
        0: r = 32'd500000;
        1: r = 32'd0;
        2: r = 32'd30_000_000;
        3: r = 32'd1;
        4: r = $urandom_range(1, 60_000_000);
        5: r = $urandom_range(1, 100_000);
        default: r = $urandom;
      endcase
      r_norm = (r == 32'd0) ? 32'd1 : r;
      do_reset();
      rate_in = r; en = 1'b1;
      el = 0;
      do begin @(negedge clk); el++; end while (busy !== 1'b0 && el < 50);
      while (busy !== 1'b0 && el < 50) begin @(negedge clk); el++; end
      tests_run += 2;
      if (period_top !== calc_top(r)) begin tests_failed++; $display("[TB] FAIL div_top(rate=%0d): got %0d expected %0d", r, period_top, calc_top(r)); end
      if (rate !== r_norm) begin tests_failed++; $display("[TB] FAIL div_rate(rate=%0d): got %0d expected %0d", r, rate, r_norm); end
      if (calc_top(r) == 32'd0) begin
        bad = 0;
        for (int k = 0; k < 5; k++) begin
          if (cnt !== 32'd0 || period_start !== 1'b1) bad++;
          @(negedge clk);
        end
        tests_run++;
        if (bad != 0) begin tests_failed++; $display("[TB] FAIL top0_cnt_stuck(rate=%0d): got %0d bad cycles expected 0", r, bad); end
      end
    end
  endtask

  task automatic test_abort;
    do_reset();
    rate_in = 32'd500000; en = 1'b1;
    repeat (40) @(negedge clk);
    en = 1'b0;
    repeat (60) @(negedge clk);
    rate_in = 32'd1000; en = 1'b1;
    repeat (10) @(negedge clk);
    tests_run++;
    if (busy !== 1'b1) begin tests_failed++; $display("[TB] FAIL abort_in_calc: got %0b expected 1", busy); end
    en = 1'b0;
    repeat (2) @(negedge clk);
    tests_run += 4;
    if (busy !== 1'b0) begin tests_failed++; $display("[TB] FAIL abort_busy: got %0b expected 0", busy); end
    if (period_top !== calc_top(32'd500000)) begin tests_failed++; $display("[TB] FAIL abort_top: got %0d expected %0d", period_top, calc_top(32'd500000)); end
    if (rate !== 32'd500000) begin tests_failed++; $display("[TB] FAIL abort_rate: got %0d expected 500000", rate); end
    if (cnt !== 32'd0) begin tests_failed++; $display("[TB] FAIL abort_cnt: got %0d expected 0", cnt); end
  endtask

  task automatic test_ramp;
    do_reset();
    rate_in = 32'd500000; step = 8'd10; periods_per_step = 16'd1; hold_periods = 16'd2;
    build_schedule(26, 10, 1, 2);
    en = 1'b1;
    run_schedule(26, calc_top(32'd500000), "ramp");
  endtask

  task automatic test_saturate;
    do_reset();
    rate_in = 32'd500000; step = 8'd30; periods_per_step = 16'd3; hold_periods = 16'd1;
    build_schedule(30, 30, 3, 1);
    en = 1'b1;
    run_schedule(30, calc_top(32'd500000), "saturate");
  endtask

  task automatic test_random_ramps;
    logic [31:0] r;
    int unsigned st, pp, hd;
    for (int it = 0; it < 3; it++) begin
      do_reset();
      r  = $urandom_range(200_000, 2_000_000);
      st = $urandom_range(0, 120);
      pp = $urandom_range(0, 3);
      hd = $urandom_range(0, 3);
      $display("[TB] random ramp %0d: rate=%0d step=%0d pps=%0d hold=%0d", it, r, st, pp, hd);
      rate_in = r; step = 8'(st); periods_per_step = 16'(pp); hold_periods = 16'(hd);
      build_schedule(25, st, pp, hd);
      en = 1'b1;
      run_schedule(25, calc_top(r), "random");
    end
  endtask

  task automatic test_en_drop;
    int unsigned el;
    logic [31:0] last_cnt;
    do_reset();
    rate_in = 32'd100000; step = 8'd50; periods_per_step = 16'd1; hold_periods = 16'd0;
    build_schedule(3, 50, 1, 0);
    en = 1'b1;
    run_schedule(3, calc_top(32'd100000), "en_drop");
    el = 0;
    while (cnt !== 32'd100 && el < 400) begin @(negedge clk); el++; end
    en = 1'b0;
    el = 0;
    do begin last_cnt = cnt; @(negedge clk); el++; end while (cnt !== 32'd0 && el < 1000);
    tests_run += 6;
    if (el != 170) begin tests_failed++; $display("[TB] FAIL drop_to_boundary: got %0d expected 170", el); end
    if (last_cnt !== 32'd269) begin tests_failed++; $display("[TB] FAIL drop_last_cnt: got %0d expected 269", last_cnt); end
    if (duty !== DMIN) begin tests_failed++; $display("[TB] FAIL drop_duty: got %0d expected %0d", duty, DMIN); end
    if (phase !== 2'd0) begin tests_failed++; $display("[TB] FAIL drop_phase: got %0d expected 0", phase); end
    if (period_start !== 1'b0) begin tests_failed++; $display("[TB] FAIL drop_start: got %0b expected 0", period_start); end
    if (busy !== 1'b0) begin tests_failed++; $display("[TB] FAIL drop_busy: got %0b expected 0", busy); end
    repeat (5) @(negedge clk);
    tests_run++;
    if (cnt !== 32'd0) begin tests_failed++; $display("[TB] FAIL idle_cnt: got %0d expected 0", cnt); end
  endtask

  task automatic test_async_reset;
    do_reset();
    rate_in = 32'd500000; step = 8'd50; periods_per_step = 16'd1; hold_periods = 16'd0;
    en = 1'b1;
    repeat (200) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    tests_run += 7;
    if (cnt !== 32'd0) begin tests_failed++; $display("[TB] FAIL async_cnt: got %0d expected 0", cnt); end
    if (duty !== DMIN) begin tests_failed++; $display("[TB] FAIL async_duty: got %0d expected %0d", duty, DMIN); end
    if (rate !== 32'd0) begin tests_failed++; $display("[TB] FAIL async_rate: got %0d expected 0", rate); end
    if (period_top !== 32'd0) begin tests_failed++; $display("[TB] FAIL async_top: got %0d expected 0", period_top); end
    if (period_start !== 1'b0) begin tests_failed++; $display("[TB] FAIL async_start: got %0b expected 0", period_start); end
    if (busy !== 1'b0) begin tests_failed++; $display("[TB] FAIL async_busy: got %0b expected 0", busy); end
    if (phase !== 2'd0) begin tests_failed++; $display("[TB] FAIL async_phase: got %0d expected 0", phase); end
    en = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    tests_run = 0;
    tests_failed = 0;
    rst_n = 1'b0;
    en = 1'b0;
    rate_in = 32'd0;
    step = 8'd0;
    periods_per_step = 16'd0;
    hold_periods = 16'd0;
    test_reset();
    test_latency_and_rate_change();
    test_divider();
    test_abort();
    test_ramp();
    test_saturate();
    test_random_ramps();
    test_en_drop();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
